// File: rtl/sr_drive_sequencer.sv
// rtl/sr_drive_sequencer.sv - SR flop drive/readback sequencer; define SRSEQ_ABORT_ON_ERR_EN to end a run on the first mismatch
module sr_drive_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic             q_model
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DRIVE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_pattern;
    logic [WIDTH-1:0]   w_pattern_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [CNT_W-1:0]   r_err;
    logic [CNT_W-1:0]   w_err_nxt;
    logic               r_q_model;
    logic               w_q_model_nxt;
    logic               r_s;
    logic               r_r;
    logic               r_busy;
    logic               r_done;
    logic               w_s_nxt;
    logic               w_r_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_mismatch;
    logic               w_last;
    logic               w_target;

    assign w_mismatch = (q_fb != r_q_model);
    assign w_last     = (r_idx == IDX_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_pattern_nxt = r_pattern;
        w_idx_nxt     = r_idx;
        w_err_nxt     = r_err;
        w_q_model_nxt = r_q_model;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_INIT;
                    w_pattern_nxt = pattern;
                    w_idx_nxt     = '0;
                    w_err_nxt     = '0;
                end
            end
            ST_INIT: begin
                w_state_nxt   = ST_DRIVE;
                w_q_model_nxt = 1'b0;
            end
            ST_DRIVE: begin
                w_state_nxt   = ST_CHECK;
                w_q_model_nxt = r_pattern[r_idx];
            end
            ST_CHECK: begin
                if (w_mismatch && !(&r_err)) begin
                    w_err_nxt = r_err + CNT_W'(1);
                end
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRIVE;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                end
`ifdef SRSEQ_ABORT_ON_ERR_EN
                if (w_mismatch) begin
                    w_state_nxt = ST_DONE;
                    w_idx_nxt   = r_idx;
                end
`endif
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Drives are registered, so they are decoded from the state being entered;
    // the excitation table can never yield s=r=1.
    assign w_target = r_pattern[w_idx_nxt];

    always_comb begin
        w_s_nxt    = 1'b0;
        w_r_nxt    = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            ST_INIT: begin
                w_r_nxt    = 1'b1;
                w_busy_nxt = 1'b1;
            end
            ST_DRIVE: begin
                w_s_nxt    = w_target & ~w_q_model_nxt;
                w_r_nxt    = ~w_target & w_q_model_nxt;
                w_busy_nxt = 1'b1;
            end
            ST_CHECK: begin
                w_busy_nxt = 1'b1;
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pattern <= '0;
            r_idx     <= '0;
            r_err     <= '0;
            r_q_model <= 1'b0;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pattern <= w_pattern_nxt;
            r_idx     <= w_idx_nxt;
            r_err     <= w_err_nxt;
            r_q_model <= w_q_model_nxt;
            r_s       <= w_s_nxt;
            r_r       <= w_r_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign s       = r_s;
    assign r       = r_r;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err_cnt = r_err;
    assign q_model = r_q_model;

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// tb/tb_sr_drive_sequencer.sv - self-checking bench for sr_drive_sequencer
module tb_sr_drive_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       stuck = 1'b0;

    logic       s1, r1, busy1, done1, qm1, q_fb1;
    logic [7:0] err1;
    logic       s2, r2, busy2, done2, qm2, q_fb2;
    logic [1:0] err2;
    logic       q_ff1 = 1'b0;
    logic       q_ff2 = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] exp_sr_q[$];

    always #5 clk = ~clk;

    sr_drive_sequencer #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .s(s1), .r(r1), .q_fb(q_fb1), .busy(busy1), .done(done1),
        .err_cnt(err1), .q_model(qm1)
    );

    sr_drive_sequencer #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .start(start2), .pattern(pattern),
        .s(s2), .r(r2), .q_fb(q_fb2), .busy(busy2), .done(done2),
        .err_cnt(err2), .q_model(qm2)
    );

    // Ideal synchronous SR flops; stuck forces the readback low.
    always @(posedge clk) begin
        if (s1) q_ff1 <= 1'b1;
        else if (r1) q_ff1 <= 1'b0;
        if (s2) q_ff2 <= 1'b1;
        else if (r2) q_ff2 <= 1'b0;
    end
    assign q_fb1 = stuck ? 1'b0 : q_ff1;
    assign q_fb2 = stuck ? 1'b0 : q_ff2;

    task automatic build_model(input logic [7:0] pat, input bit stk, input int cmax,
                               output int doff, output int eerr, output logic eq);
        logic q;
        logic t;
        logic rb;
        exp_sr_q.delete();
        q    = 1'b0;
        eerr = 0;
        doff = 18;
        for (int i = 0; i < 8; i++) begin
            t = pat[i];
            case ({q, t})
                2'b01:   exp_sr_q.push_back(2'b10);
                2'b10:   exp_sr_q.push_back(2'b01);
                default: exp_sr_q.push_back(2'b00);
            endcase
            q  = t;
            rb = stk ? 1'b0 : t;
            if (rb !== q) begin
                if (eerr < cmax) eerr++;
`ifdef SRSEQ_ABORT_ON_ERR_EN
                doff = 4 + 2 * i;
                break;
`endif
            end
        end
        eq = q;
    endtask

    task automatic run_main(input logic [7:0] pat, input bit stk, input int restart_at,
                            input int reset_at, input string nm);
        int doff;
        int eerr;
        logic eq;
        logic [1:0] want;
        build_model(pat, stk, 255, doff, eerr, eq);
        stuck = stk;
        @(posedge clk); #1;
        start = 1'b1;
        pattern = pat;
        @(posedge clk); #1;
        start = 1'b0;
        pattern = ~pat;
        for (int off = 1; off <= doff + 2; off++) begin
            start = (off == restart_at);
            if (off == restart_at) pattern = 8'h5A;
            reset = (off == reset_at);
            @(negedge clk);
            n_checks++;
            if (s1 && r1) $display("FAIL %s illegal_sr off=%0d got s=r=1 want not both", nm, off);
            else n_pass++;
            if (reset_at > 0 && off > reset_at) begin
                n_checks++;
                if ({s1, r1, busy1, done1, err1, qm1} !== 13'd0)
                    $display("FAIL %s after_reset off=%0d got s=%b r=%b busy=%b done=%b err=%0d qm=%b want all 0",
                             nm, off, s1, r1, busy1, done1, err1, qm1);
                else n_pass++;
            end else begin
                n_checks++;
                if (busy1 !== (off < doff) || done1 !== (off == doff))
                    $display("FAIL %s busy_done off=%0d got busy=%b done=%b want busy=%b done=%b",
                             nm, off, busy1, done1, (off < doff), (off == doff));
                else n_pass++;
                if (off == 1) begin
                    n_checks++;
                    if ({s1, r1} !== 2'b01) $display("FAIL %s init_sr got %b want 01", nm, {s1, r1});
                    else n_pass++;
                end else if (off < doff) begin
                    n_checks++;
                    if (off % 2 == 0) begin
                        if (exp_sr_q.size() == 0) begin
                            $display("FAIL %s drive_sr off=%0d got %b want none queued", nm, off, {s1, r1});
                        end else begin
                            want = exp_sr_q.pop_front();
                            if ({s1, r1} !== want)
                                $display("FAIL %s drive_sr off=%0d got %b want %b", nm, off, {s1, r1}, want);
                            else n_pass++;
                        end
                    end else begin
                        if ({s1, r1} !== 2'b00) $display("FAIL %s check_sr off=%0d got %b want 00", nm, off, {s1, r1});
                        else n_pass++;
                    end
                end
                if (off >= doff) begin
                    n_checks++;
                    if (err1 !== 8'(eerr)) $display("FAIL %s err_cnt off=%0d got %0d want %0d", nm, off, err1, eerr);
                    else n_pass++;
                end
                if (off == doff) begin
                    n_checks++;
                    if (qm1 !== eq) $display("FAIL %s q_model got %b want %b", nm, qm1, eq);
                    else n_pass++;
                end
            end
            @(posedge clk); #1;
        end
        if (reset_at == 0) begin
            n_checks++;
            if (exp_sr_q.size() != 0) $display("FAIL %s drives_left got %0d want 0", nm, exp_sr_q.size());
            else n_pass++;
        end
        start = 1'b0;
        reset = 1'b0;
        exp_sr_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({s1, r1, busy1, done1, err1, qm1} !== 13'd0)
            $display("FAIL reset_state got s=%b r=%b busy=%b done=%b err=%0d qm=%b want all 0",
                     s1, r1, busy1, done1, err1, qm1);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_ideal();
        run_main(8'b1011_0010, 1'b0, 0, 0, "ideal");
    endtask

    task automatic test_stuck();
        run_main(8'b1011_0010, 1'b1, 0, 0, "stuck0");
    endtask

    task automatic test_restart_ignored();
        run_main(8'b1011_0010, 1'b0, 5, 0, "restart");
    endtask

    task automatic test_reset_mid_run();
        run_main(8'b1011_0010, 1'b0, 0, 7, "midreset");
    endtask

    task automatic test_abort_pattern();
        run_main(8'h04, 1'b1, 0, 0, "bit2");
    endtask

    task automatic test_saturate();
        int doff;
        int eerr;
        logic eq;
        build_model(8'hFF, 1'b1, 3, doff, eerr, eq);
        stuck = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b1;
        pattern = 8'hFF;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int off = 1; off <= doff + 1; off++) begin
            @(negedge clk);
            n_checks++;
            if ((s2 && r2) || done2 !== (off == doff))
                $display("FAIL sat_run off=%0d got s=%b r=%b done=%b want no s=r=1 done=%b",
                         off, s2, r2, done2, (off == doff));
            else n_pass++;
            if (off == doff) begin
                n_checks++;
                if (err2 !== 2'(eerr)) $display("FAIL sat_err got %0d want %0d", err2, eerr);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        stuck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck();
        test_restart_ignored();
        test_reset_mid_run();
        test_saturate();
        test_abort_pattern();
        test_ideal();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
